// File: rtl/demosaic_pkg.sv
// Shared types and defaults for the demosaic line-window block.
package demosaic_pkg;

    localparam int unsigned PIX_W_DEF  = 8;
    localparam int unsigned IMG_W_DEF  = 640;
    localparam int unsigned NUM_LINES  = 4;
    localparam int unsigned LINE_CNT_W = 3;

    typedef logic [LINE_CNT_W-1:0] line_cnt_t;

    localparam line_cnt_t LINE_FULL = line_cnt_t'(NUM_LINES);

    // Line counter increment that sticks once all buffers are primed.
    function automatic line_cnt_t line_sat_inc(input line_cnt_t v);
        return (v == LINE_FULL) ? v : v + line_cnt_t'(1);
    endfunction

endpackage

// File: rtl/demosaic_line_ram.sv
// Single-port line buffer: combinational read of the addressed word, write at
// the clock edge, so a same-address access returns the old contents.
module demosaic_line_ram #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  wdata,
    output logic [PIX_W-1:0]  rdata_c
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/demosaic_line_window.sv
// Five-row vertical window over a raster Bayer stream using four chained line
// buffers. Optional macro DEMOSAIC_LW_ZERO_PAD_EN: emit from row 0 with taps of
// rows not yet received this frame forced to zero.
module demosaic_line_window
    import demosaic_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEF,
    parameter int unsigned IMG_W = IMG_W_DEF
) (
    input  logic             INCLK,
    input  logic             RST,
    input  logic             VSYNC,
    input  logic             HSYNC,
    input  logic             IN_EN,
    input  logic [PIX_W-1:0] IN_DATA,
    output logic [PIX_W-1:0] DATA1,
    output logic [PIX_W-1:0] DATA2,
    output logic [PIX_W-1:0] DATA3,
    output logic [PIX_W-1:0] DATA4,
    output logic [PIX_W-1:0] DATA5,
    output logic             O_EN,
    output logic             O_HSYNC,
    output logic             ERR_OVF
);

    localparam int unsigned ADDR_W = $clog2(IMG_W);
    localparam int unsigned COL_W  = $clog2(IMG_W + 1);

    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] col_eff;
    line_cnt_t        line_q;
    line_cnt_t        line_eff;
    logic             seen_q;
    logic             seen_eff;
    logic             in_ok;
    logic             oen_c;
    logic             ovf_c;

    logic [PIX_W-1:0] ram_wdata [NUM_LINES];
    logic [PIX_W-1:0] ram_rdata [NUM_LINES];
    logic [PIX_W-1:0] tap       [NUM_LINES];

    // Buffer k holds row n-k-1; each one feeds the next as it is read out.
    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        if (k == 0) begin : g_head
            assign ram_wdata[k] = IN_DATA;
        end else begin : g_chain
            assign ram_wdata[k] = ram_rdata[k-1];
        end

        demosaic_line_ram #(
            .PIX_W  (PIX_W),
            .DEPTH  (IMG_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk     (INCLK),
            .we      (in_ok),
            .addr    (ADDR_W'(col_eff)),
            .wdata   (ram_wdata[k]),
            .rdata_c (ram_rdata[k])
        );
    end

    // Syncs take effect in their own cycle so a coincident pixel lands on column 0.
    always_comb begin
        col_eff  = col_q;
        line_eff = line_q;
        seen_eff = seen_q;
        in_ok    = 1'b0;
        ovf_c    = 1'b0;
        oen_c    = 1'b0;
        for (int k = 0; k < NUM_LINES; k++) begin
            tap[k] = ram_rdata[k];
        end

        if (VSYNC) begin
            col_eff  = '0;
            line_eff = '0;
            seen_eff = 1'b0;
        end else if (HSYNC) begin
            col_eff  = '0;
            seen_eff = 1'b0;
            if (seen_q) begin
                line_eff = line_sat_inc(line_q);
            end
        end

        in_ok = IN_EN && (col_eff != COL_W'(IMG_W));
        ovf_c = IN_EN && !in_ok;

`ifdef DEMOSAIC_LW_ZERO_PAD_EN
        oen_c = in_ok;
        for (int k = 0; k < NUM_LINES; k++) begin
            if (line_eff <= line_cnt_t'(k)) begin
                tap[k] = '0;
            end
        end
`else
        oen_c = in_ok && (line_eff == LINE_FULL);
`endif
    end

    always_ff @(posedge INCLK or posedge RST) begin
        if (RST) begin
            col_q   <= '0;
            line_q  <= '0;
            seen_q  <= 1'b0;
            O_EN    <= 1'b0;
            O_HSYNC <= 1'b0;
            ERR_OVF <= 1'b0;
            DATA1   <= '0;
            DATA2   <= '0;
            DATA3   <= '0;
            DATA4   <= '0;
            DATA5   <= '0;
        end else begin
            col_q   <= col_eff + COL_W'(in_ok);
            line_q  <= line_eff;
            seen_q  <= seen_eff | in_ok;
            O_EN    <= oen_c;
            O_HSYNC <= HSYNC;
            if (ovf_c) begin
                ERR_OVF <= 1'b1;
            end
            if (oen_c) begin
                DATA5 <= IN_DATA;
                DATA4 <= tap[0];
                DATA3 <= tap[1];
                DATA2 <= tap[2];
                DATA1 <= tap[3];
            end
        end
    end

endmodule
